uart_event_queue: RTL and testbench

- Buffers single-byte game event codes ('R' game over, 'H' hit, '0'..'4' mole index) from the game/UART glue logic, then drains them one at a time into the uart_tx transmitter using its tx_start/busy handshake.
- Sits directly upstream of uart_tx, replacing the direct one-shot writes so events raised while the transmitter is busy are not lost.

---
 rtl/uart_event_queue.sv | 192 +++++++++++++++++++
 tb/tb_uart_event_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_event_queue.sv
// uart_event_queue
//   Buffers single-byte game event codes ('R', 'H', '0'..'4') and drains them
//   one at a time into uart_tx using its tx_start/busy handshake, so events
//   raised while the transmitter is busy are not lost.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   ADDR_BITS    log2(DEPTH)
//   ACK_TIMEOUT  cycles to wait for tx_busy after tx_start before giving up
//
// Ports
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   clear       in   synchronous flush of queued bytes
//   evt_valid   in   one-cycle strobe, evt_data offered this cycle
//   evt_data    in   event byte
//   tx_busy     in   uart_tx busy flag
//   tx_start    out  one-cycle start pulse to uart_tx
//   tx_data     out  byte to uart_tx, held until the handshake finishes
//   fifo_empty  out  level == 0
//   fifo_full   out  level == DEPTH
//   level       out  number of queued bytes, 0..DEPTH
//   drop_count  out  bytes rejected while full, saturating at 255
//
// Build option
//   UART_EVT_DEDUP_EN  when defined, a byte equal to the most recently pushed
//                      byte is discarded while that byte is still queued.

module uart_event_queue #(
    parameter int DEPTH       = 8,
    parameter int ADDR_BITS   = 3,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 evt_valid,
    input  logic [7:0]           evt_data,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [ADDR_BITS:0]   level,
    output logic [7:0]           drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SENT = 2'd1,
        BUSY = 2'd2
    } state_t;

    localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE_LEVEL  = (ADDR_BITS+1)'(1);
    localparam logic [7:0]         ACK_LAST   = 8'(ACK_TIMEOUT - 1);

    logic [7:0]           r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wrPtr;
    logic [ADDR_BITS-1:0] r_rdPtr;
    logic [ADDR_BITS:0]   r_level;
    logic [7:0]           r_dropCount;
    state_t               r_state;
    logic [7:0]           r_ackCnt;
    logic                 r_txStart;
    logic [7:0]           r_txData;

    logic w_dup;
    logic w_offer;
    logic w_push;
    logic w_drop;
    logic w_pop;

    assign fifo_empty = (r_level == '0);
    assign fifo_full  = (r_level == FULL_LEVEL);
    assign level      = r_level;
    assign drop_count = r_dropCount;
    assign tx_start   = r_txStart;
    assign tx_data    = r_txData;

    // The only pop is the IDLE issue; fullness is the registered level, so a
    // push at full is rejected even if the same edge pops.
    assign w_pop   = (r_state == IDLE) && !fifo_empty && !tx_busy;
    assign w_offer = evt_valid && !clear && !w_dup;
    assign w_push  = w_offer && !fifo_full;
    assign w_drop  = w_offer && fifo_full;

`ifdef UART_EVT_DEDUP_EN
    logic [7:0] r_lastByte;
    logic       r_lastValid;

    assign w_dup = r_lastValid && (evt_data == r_lastByte);

    // Remember the last pushed byte while it is still in the queue; once the
    // queue drains empty a repeat of it is a genuinely new event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lastByte  <= 8'h00;
            r_lastValid <= 1'b0;
        end else if (clear) begin
            r_lastValid <= 1'b0;
        end else if (w_push) begin
            r_lastByte  <= evt_data;
            r_lastValid <= 1'b1;
        end else if (w_pop && (r_level == ONE_LEVEL)) begin
            r_lastValid <= 1'b0;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Storage array; not reset because the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= evt_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Drop counter survives clear so overflow history is not lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dropCount <= 8'h00;
        end else if (w_drop && (r_dropCount != 8'hFF)) begin
            r_dropCount <= r_dropCount + 8'h01;
        end
    end

    // Handshake FSM. SENT waits for uart_tx to acknowledge with busy; if it
    // never does, the byte is treated as sent so the queue cannot stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ackCnt  <= 8'h00;
            r_txStart <= 1'b0;
            r_txData  <= 8'h00;
        end else begin
            r_txStart <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_txData  <= r_mem[r_rdPtr];
                        r_txStart <= 1'b1;
                        r_ackCnt  <= 8'h00;
                        r_state   <= SENT;
                    end
                end
                SENT: begin
                    if (tx_busy) begin
                        r_state <= BUSY;
                    end else if (r_ackCnt == ACK_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_ackCnt <= r_ackCnt + 8'h01;
                    end
                end
                BUSY: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_event_queue.sv
// tb_uart_event_queue
//   Scoreboard bench for uart_event_queue: accepted bytes are queued when
//   offered and compared in order against tx_data at each tx_start. A small
//   uart_tx model raises busy one cycle after a start pulse.

module tb_uart_event_queue;

    localparam int DEPTH     = 8;
    localparam int ADDR_BITS = 3;
    localparam int ACK       = 4;

    logic                 clock      = 1'b0;
    logic                 reset      = 1'b0;
    logic                 clear      = 1'b0;
    logic                 evt_valid  = 1'b0;
    logic [7:0]           evt_data   = 8'h00;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [ADDR_BITS:0]   level;
    logic [7:0]           drop_count;

    logic busyManual = 1'b0;
    logic busyModel  = 1'b0;
    logic modelEn    = 1'b0;
    int   modelLen   = 100;

    int   checks       = 0;
    int   errors       = 0;
    int   cycleCnt     = 0;
    int   startCount   = 0;
    int   lastStartCyc = 0;
    int   prevStartCyc = 0;
    logic prevStart    = 1'b0;
    logic prevNegBusy  = 1'b0;
    logic [7:0] expQ[$];

    assign tx_busy = busyManual | busyModel;

    uart_event_queue #(
        .DEPTH(DEPTH),
        .ADDR_BITS(ADDR_BITS),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .level(level),
        .drop_count(drop_count)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Edge counter used for latency and timeout spacing
    always @(posedge clock) cycleCnt++;

    // Counts one comparison and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // Offers one byte for one cycle; bytes the DUT should accept go to the scoreboard
    task automatic applyStimulus(input logic [7:0] d, input bit expectAccept);
        evt_valid = 1'b1;
        evt_data  = d;
        if (expectAccept) expQ.push_back(d);
        @(posedge clock);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Bounded wait for a number of start pulses
    task automatic waitStarts(input int target, input int maxCycles, input string tag);
        int n = 0;
        while (startCount < target && n < maxCycles) begin
            @(posedge clock);
            #2;
            n++;
        end
        checkOutput(tag, startCount, target);
    endtask

    // Bounded wait for the scoreboard and the queue to empty with uart_tx idle
    task automatic waitDrain(input int maxCycles, input string tag);
        int n = 0;
        while (!(expQ.size() == 0 && fifo_empty && !tx_busy) && n < maxCycles) begin
            @(posedge clock);
            #2;
            n++;
        end
        checkOutput(tag, expQ.size(), 0);
        tick(ACK + 3);
    endtask

    // Monitor: every start pulse must be one cycle wide, issued while uart_tx
    // was idle, and carry the oldest outstanding scoreboard byte
    always @(negedge clock) begin
        if (reset && tx_start) begin
            startCount++;
            prevStartCyc = lastStartCyc;
            lastStartCyc = cycleCnt;
            checkOutput("tx_start width", prevStart, 1'b0);
            checkOutput("busy at issue", prevNegBusy, 1'b0);
            checkOutput("scoreboard has byte at tx_start", expQ.size() > 0, 1'b1);
            if (expQ.size() > 0) begin
                checkOutput("tx_data order", tx_data, expQ.pop_front());
            end
        end
        prevStart   = tx_start;
        prevNegBusy = tx_busy;
    end

    // uart_tx model: busy rises the cycle after a start pulse and holds modelLen cycles
    initial begin
        forever begin
            @(negedge clock);
            if (modelEn && reset && tx_start) begin
                @(posedge clock);
                #1;
                busyModel = 1'b1;
                repeat (modelLen) @(posedge clock);
                #1;
                busyModel = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int pushEdge;
        int dropBase;

        // Reset state
        #23;
        checkOutput("reset tx_start", tx_start, 1'b0);
        checkOutput("reset tx_data", tx_data, 8'h00);
        checkOutput("reset fifo_empty", fifo_empty, 1'b1);
        checkOutput("reset fifo_full", fifo_full, 1'b0);
        checkOutput("reset level", level, 0);
        checkOutput("reset drop_count", drop_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick(2);

        // Single byte into idle transmitter
        modelEn  = 1'b1;
        modelLen = 100;
        base     = startCount;
        applyStimulus(8'h48, 1'b1);
        pushEdge = cycleCnt;
        checkOutput("single level after push", level, 1);
        waitStarts(base + 1, 10, "single issued");
        checkOutput("single latency", lastStartCyc, pushEdge + 1);
        checkOutput("single level after pop", level, 0);
        checkOutput("single tx_data held", tx_data, 8'h48);
        tick(110);
        checkOutput("single no second start", startCount, base + 1);
        waitDrain(50, "single drain");

        // Burst while busy
        busyManual = 1'b1;
        base       = startCount;
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b1);
        applyStimulus(8'h52, 1'b1);
        checkOutput("burst level", level, 4);
        tick(3);
        checkOutput("burst held while busy", startCount, base);
        busyManual = 1'b0;
        waitDrain(4 * 120, "burst drain");
        checkOutput("burst starts", startCount, base + 4);

        // Overflow, then push at full with a same-cycle pop
        busyManual = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h10 + i), i < DEPTH);
        checkOutput("overflow fifo_full", fifo_full, 1'b1);
        checkOutput("overflow level", level, DEPTH);
        checkOutput("overflow drop_count", drop_count, 2);
        busyManual = 1'b0;
        applyStimulus(8'h1A, 1'b0);
        checkOutput("push+pop at full drop_count", drop_count, 3);
        checkOutput("push+pop at full level", level, DEPTH - 1);
        waitDrain(9 * 120, "overflow drain");

        // Clear while a byte is in flight
        base = startCount;
        applyStimulus(8'h5A, 1'b1);
        waitStarts(base + 1, 10, "clear in-flight issued");
        tick(3);
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h60 + i), 1'b0);
        checkOutput("clear level before", level, 5);
        dropBase  = drop_count;
        clear     = 1'b1;
        evt_valid = 1'b1;
        evt_data  = 8'h66;
        @(posedge clock);
        #1;
        clear     = 1'b0;
        evt_valid = 1'b0;
        checkOutput("clear level", level, 0);
        checkOutput("clear fifo_empty", fifo_empty, 1'b1);
        checkOutput("clear drop_count kept", drop_count, dropBase);
        checkOutput("clear in-flight tx_data", tx_data, 8'h5A);
        tick(110);
        checkOutput("clear no flushed start", startCount, base + 1);
        waitDrain(50, "clear drain");

        // Pointer wrap while draining
        modelLen = 20;
        base     = startCount;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'(8'hA0 + i), 1'b1);
            tick(14);
        end
        waitDrain(12 * 30, "wrap drain");
        checkOutput("wrap starts", startCount, base + 12);

        // Acknowledge timeout
        modelEn = 1'b0;
        base    = startCount;
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b1);
        waitStarts(base + 2, 20, "timeout both issued");
        checkOutput("timeout reissue gap", lastStartCyc - prevStartCyc, ACK + 1);
        waitDrain(20, "timeout drain");
        modelEn  = 1'b1;
        modelLen = 100;

        // Reset during BUSY
        base = startCount;
        applyStimulus(8'h77, 1'b1);
        waitStarts(base + 1, 10, "reset in-flight issued");
        tick(3);
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h79, 1'b0);
        checkOutput("reset-mid level before", level, 2);
        reset = 1'b0;
        #1;
        checkOutput("reset-mid tx_start", tx_start, 1'b0);
        checkOutput("reset-mid tx_data", tx_data, 8'h00);
        checkOutput("reset-mid level", level, 0);
        checkOutput("reset-mid fifo_empty", fifo_empty, 1'b1);
        checkOutput("reset-mid drop_count", drop_count, 0);
        tick(3);
        reset = 1'b1;
        tick(150);
        checkOutput("reset-mid no start", startCount, base + 1);

        // Repeated codes while busy
        busyManual = 1'b1;
`ifdef UART_EVT_DEDUP_EN
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h34, 1'b1);
        checkOutput("dedup level", level, 2);
`else
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h34, 1'b1);
        checkOutput("repeat level", level, 3);
`endif
        checkOutput("repeat drop_count", drop_count, 0);
        busyManual = 1'b0;
        waitDrain(3 * 120, "repeat drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
